data_memory_arbiter: RTL and testbench

//  Shares the single-port data_memory between two requesters: port 0 = datapath

---
 rtl/data_memory_arbiter.sv | 120 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single-port data memory between the datapath
// (port 0) and the photonic network interface (port 1). Fixed priority to port 0,
// lockable bursts, and registered read data one cycle after the grant.
// Optional feature: define DM_ARB_STARVE_GUARD_EN to force a port-1 grant after
// STARVE_LIMIT consecutive denied cycles.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_lock0_eff;
  logic                  w_lock1_eff;
  logic                  w_force1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  // A held lock only binds while its owner keeps requesting; dropping req
  // hands the memory back to normal arbitration in that same cycle.
  assign w_lock0_eff = (r_state == LOCK0) && req0;
  assign w_lock1_eff = (r_state == LOCK1) && req1;

`ifdef DM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  // Count consecutive cycles port 1 waits; any grant or idle cycle restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_starve_cnt <= '0;
    else if (!req1 || w_gnt1)         r_starve_cnt <= '0;
    else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // At the limit port 1 overrides both port-0 priority and a port-0 lock.
  assign w_force1 = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) && req1 && !w_lock1_eff;
`else
  assign w_force1 = 1'b0;
`endif

  // Grant decision and next state; grants are suppressed while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_next = IDLE;
    if (w_lock1_eff)      w_gnt1 = 1'b1;
    else if (w_force1)    w_gnt1 = 1'b1;
    else if (w_lock0_eff) w_gnt0 = 1'b1;
    else if (req0)        w_gnt0 = 1'b1;
    else if (req1)        w_gnt1 = 1'b1;
    if (!rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0 && lock0)      w_next = LOCK0;
    else if (w_gnt1 && lock1) w_next = LOCK1;
  end

  // State register; reset discards any lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Capture read data one cycle after a granted read; writes never raise rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 && !we0;
      r_rvalid1 <= w_gnt1 && !we1;
      if (w_gnt0 && !we0) r_rdata0 <= mem_rdata;
      if (w_gnt1 && !we1) r_rdata1 <= mem_rdata;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_we    = (w_gnt0 && we0) || (w_gnt1 && we1);
  assign mem_addr  = w_gnt1 ? addr1 : addr0;
  assign mem_wdata = w_gnt1 ? wdata1 : wdata0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: behavioural memory behind the
// arbiter, a reference copy of its contents, and per-port queues of expected
// read data pushed at the grant and popped when rvalid is due.
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        rst, req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] exp_d;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  data_memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 16'h0001; addr1 = 16'h0002;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: gnt0=%b gnt1=%b want 0 0", gnt0, gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: %b %b want 0 0", rvalid0, rvalid1); end
    checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin errors++; $display("FAIL reset_rdata: %h %h want 0 0", rdata0, rdata1); end
    @(negedge clk); rst = 1; #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL release_gnt: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
    q0.push_back(ref_mem[8'h01]);
    @(negedge clk);
    idle_inputs();
    exp_d = q0.pop_front();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== exp_d) begin errors++; $display("FAIL release_read: rvalid0=%b rdata0=%h want 1 %h", rvalid0, rdata0, exp_d); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF; #1;
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt: gnt0=%b mem_we=%b want 1 1", gnt0, mem_we); end
    ref_mem[8'h10] = 16'hBEEF;
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: rvalid0=%b want 0", rvalid0); end
    req0 = 0; we0 = 0; req1 = 1; we1 = 0; addr1 = 16'h0010; #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rd1_gnt: gnt1=%b gnt0=%b we=%b want 1 0 0", gnt1, gnt0, mem_we); end
    q1.push_back(ref_mem[8'h10]);
    @(negedge clk);
    idle_inputs();
    exp_d = q1.pop_front();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d || rvalid0 !== 1'b0) begin errors++; $display("FAIL rd1_data: rvalid1=%b rdata1=%h rvalid0=%b want 1 %h 0", rvalid1, rdata1, rvalid0, exp_d); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    req0 = 1; addr0 = 16'h0004; req1 = 1; addr1 = 16'h0008; #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL prio_gnt: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
    checks++; if (mem_addr !== 16'h0004) begin errors++; $display("FAIL prio_addr: got %h want 0004", mem_addr); end
    q0.push_back(ref_mem[8'h04]);
    @(negedge clk);
    exp_d = q0.pop_front();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== exp_d) begin errors++; $display("FAIL prio_rd0: rvalid0=%b rdata0=%h want 1 %h", rvalid0, rdata0, exp_d); end
    req0 = 0; #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL prio_gnt1: gnt1=%b gnt0=%b want 1 0", gnt1, gnt0); end
    q1.push_back(ref_mem[8'h08]);
    @(negedge clk);
    idle_inputs();
    exp_d = q1.pop_front();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d || rvalid0 !== 1'b0) begin errors++; $display("FAIL prio_rd1: rvalid1=%b rdata1=%h rvalid0=%b want 1 %h 0", rvalid1, rdata1, rvalid0, exp_d); end
  endtask

  task automatic test_lock_burst();
    @(negedge clk);
    req1 = 1; lock1 = 1; addr1 = 16'h0020; #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL lock_beat0: gnt1=%b want 1", gnt1); end
    q1.push_back(ref_mem[8'h20]);
    for (int b = 1; b < 3; b++) begin
      @(negedge clk);
      exp_d = q1.pop_front();
      checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d) begin errors++; $display("FAIL lock_rd%0d: rvalid1=%b rdata1=%h want 1 %h", b, rvalid1, rdata1, exp_d); end
      req0 = 1; addr0 = 16'h0030; addr1 = 16'h0020 + 16'(b); #1;
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_beat%0d: gnt1=%b gnt0=%b want 1 0", b, gnt1, gnt0); end
      q1.push_back(ref_mem[8'h20 + 8'(b)]);
    end
    @(negedge clk);
    exp_d = q1.pop_front();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d) begin errors++; $display("FAIL lock_rd_last: rvalid1=%b rdata1=%h want 1 %h", rvalid1, rdata1, exp_d); end
    req1 = 0; lock1 = 0; #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL lock_release: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); end
    q0.push_back(ref_mem[8'h30]);
    @(negedge clk);
    idle_inputs();
    exp_d = q0.pop_front();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== exp_d || rvalid1 !== 1'b0) begin errors++; $display("FAIL lock_rd0: rvalid0=%b rdata0=%h rvalid1=%b want 1 %h 0", rvalid0, rdata0, rvalid1, exp_d); end
  endtask

  task automatic test_starve();
    logic exp1;
    @(negedge clk);
    req0 = 1; req1 = 1; addr0 = 16'h0040; addr1 = 16'h0041;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++; if (rvalid0 !== (q0.size() != 0) || rvalid1 !== (q1.size() != 0)) begin errors++; $display("FAIL starve_rvalid c%0d: %b %b want %b %b", c, rvalid0, rvalid1, q0.size() != 0, q1.size() != 0); end
        if (q0.size() != 0) begin exp_d = q0.pop_front(); checks++; if (rdata0 !== exp_d) begin errors++; $display("FAIL starve_rd0 c%0d: got %h want %h", c, rdata0, exp_d); end end
        if (q1.size() != 0) begin exp_d = q1.pop_front(); checks++; if (rdata1 !== exp_d) begin errors++; $display("FAIL starve_rd1 c%0d: got %h want %h", c, rdata1, exp_d); end end
      end
      #1;
`ifdef DM_ARB_STARVE_GUARD_EN
      exp1 = ((c % 5) == 4);
`else
      exp1 = 1'b0;
`endif
      checks++; if (gnt1 !== exp1 || gnt0 !== !exp1) begin errors++; $display("FAIL starve_gnt c%0d: gnt0=%b gnt1=%b want %b %b", c, gnt0, gnt1, !exp1, exp1); end
      if (exp1) q1.push_back(ref_mem[8'h41]); else q0.push_back(ref_mem[8'h40]);
    end
    @(negedge clk);
    idle_inputs();
    q0.delete(); q1.delete();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    req0 = 1; lock0 = 1; addr0 = 16'h0050; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt: gnt0=%b want 1", gnt0); end
    @(posedge clk); #2;
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL mid_rvalid_pre: rvalid0=%b want 1", rvalid0); end
    rst = 0; #1;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h0 || gnt0 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL mid_reset: rvalid0=%b rdata0=%h gnt0=%b we=%b want 0 0 0 0", rvalid0, rdata0, gnt0, mem_we); end
    @(negedge clk);
    rst = 1; idle_inputs(); #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_idle_gnt: %b %b want 0 0", gnt0, gnt1); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL mid_spurious: rvalid %b %b want 0 0", rvalid0, rvalid1); end
    req1 = 1; addr1 = 16'h0051; #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL mid_post_gnt1: gnt1=%b gnt0=%b want 1 0", gnt1, gnt0); end
    q1.push_back(ref_mem[8'h51]);
    @(negedge clk);
    idle_inputs();
    exp_d = q1.pop_front();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d || rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_post_rd: rvalid1=%b rdata1=%h rvalid0=%b want 1 %h 0", rvalid1, rdata1, rvalid0, exp_d); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (16'(i) * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = (16'(i) * 16'h0101) ^ 16'h5A5A;
    end
    rst = 1; idle_inputs();
    test_reset();
    test_write_read();
    test_priority();
    test_lock_burst();
    test_starve();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
